dual_issue_instr_queue: RTL and testbench
=========================================

# dual_issue_instr_queue

Show-ahead instruction queue between dual-fetch and the dual-issue decode stage. Accepts up to two fetched instructions per cycle with their PCs and presents the two oldest entries as decode slot A (older) and slot B (younger). Consumes the hazard unit's A_STALL/B_STALL decisions: it holds the pair, issues A alone, or issues both. A flush from branch/jump resolution empties it.

## Interface
- DEPTH, 8, entry count; power of two, ≥4
- XLEN, 32, instruction and PC width
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  2  bit0 = fetch slot A (older), bit1 = fetch slot B; bit1 honoured only when bit0 = 1
- in_instr_a, in_instr_b  in  XLEN  fetched instruction words
- in_pc_a, in_pc_b  in  XLEN  their PCs
- in_ready  out  1  high when free entries ≥ 2
- stall_a  in  1  hazard A_STALL: issue nothing this cycle
- stall_b  in  1  hazard B_STALL: issue slot A only
- flush  in  1  discard all entries
- out_valid_a, out_valid_b  out  1  head / head+1 present for decode
- out_instr_a, out_instr_b  out  XLEN  head instructions; 0 when the matching valid is low
- out_pc_a, out_pc_b  out  XLEN  head PCs; 0 when the matching valid is low
- count  out  $clog2(DEPTH)+1  occupancy

## Operation
- Storage: circular buffer with wr_ptr, rd_ptr (mod DEPTH) and a registered count.
- Enqueue number E: 0 if flush or !in_ready; otherwise 2 if in_valid = 2'b11, 1 if in_valid = 2'b01, and 0 for 2'b00 or 2'b10 (2'b10 is illegal and ignored). Slot A is written at wr_ptr and slot B at wr_ptr+1.
- Issue view is combinational from the head:
  - out_valid_a = count ≥ 1.
  - out_valid_b = count ≥ 2, gated by the configuration rule below.
- Dequeue number D: 0 if flush or stall_a; else 1 if stall_b or !out_valid_b; else 2. D is additionally capped at count.
- stall_a takes priority over stall_b.
- B_STALL splits the pair: old B becomes the new head A next cycle and pairs with the next entry.
- Update each edge: rd_ptr += D, wr_ptr += E, count += E − D.
- in_ready is computed from the pre-update count, so space freed by a dequeue is not reused in the same cycle.
- Flush takes priority over everything: on the next edge pointers and count go to 0 and enqueue is suppressed.
- Upstream holds its instructions while in_ready is low. Any in_valid presented while in_ready is low is not captured.
- No state machine beyond pointers/count; overflow and underflow are impossible by construction.

## Timing
- Reset (rst_n low, asynchronous):
  - wr_ptr = rd_ptr = count = 0.
  - out_valid_a/b = 0; out_instr/out_pc = 0; in_ready = 1.
- Enqueue-to-visible latency is 1 cycle: an entry written at edge N drives outputs during cycle N+1.
- stall_a/stall_b are sampled in the same cycle the outputs are presented; their effect on the head appears after the next edge.
- Flush asserted in cycle N: outputs are invalid from cycle N+1. Inputs presented in cycle N are lost.
- Reset mid-operation discards all content immediately, with no clock needed.
- Wrap-around: pointer arithmetic is modulo DEPTH. A pair that straddles index DEPTH−1→0 is legal for both write and read.

## Configuration
- IQ_CTRL_SPLIT_EN defined:
  - out_valid_b is forced 0 when out_instr_a[6:0] is JAL (1101111), JALR (1100111) or B_TYPE (1100011).
  - The control-flow instruction therefore always issues alone, and its younger neighbour stays queued until resolution or flush.
- IQ_CTRL_SPLIT_EN undefined: no opcode inspection; out_valid_b depends only on count.

## Test plan
- Reset, then enqueue in_valid = 11 with PCs 0x00/0x04, no stalls → cycle +1: both valid, pc_a = 0x00, pc_b = 0x04; cycle +2: count = 0, both valid low.
- Fill to DEPTH = 8 with 4 pairs while stall_a = 1 → count = 8, in_ready = 0. A further pair is not captured. Release stall_a → PCs drain in order two per cycle.
- Queue holding PCs 0x10, 0x14, 0x18; stall_b = 1 for one cycle → next cycle pc_a = 0x14, pc_b = 0x18, count = 2.
- Pointers near DEPTH−1, enqueue a pair straddling the wrap → both read back in order with correct PCs.
- count = 6 with flush and in_valid = 11 in the same cycle → next cycle count = 0, outputs invalid, in_ready = 1.
- IQ_CTRL_SPLIT_EN, head A = 0x0000006F (JAL) with B = ADD → out_valid_b = 0, only A issues. Without the macro → both issue.

Source files
------------

// File: rtl/dual_issue_instr_queue.sv
// rtl/dual_issue_instr_queue.sv - show-ahead dual-issue instruction queue (optional IQ_CTRL_SPLIT_EN)
module dual_issue_instr_queue #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 in_valid,
    input  logic [XLEN-1:0]            in_instr_a,
    input  logic [XLEN-1:0]            in_instr_b,
    input  logic [XLEN-1:0]            in_pc_a,
    input  logic [XLEN-1:0]            in_pc_b,
    output logic                       in_ready,
    input  logic                       stall_a,
    input  logic                       stall_b,
    input  logic                       flush,
    output logic                       out_valid_a,
    output logic                       out_valid_b,
    output logic [XLEN-1:0]            out_instr_a,
    output logic [XLEN-1:0]            out_instr_b,
    output logic [XLEN-1:0]            out_pc_a,
    output logic [XLEN-1:0]            out_pc_b,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr_b;
    logic [PW-1:0] rd_ptr_b;
    logic [1:0]    enq_num;
    logic [1:0]    deq_num;
    logic          valid_b_raw;

    assign wr_ptr_b = wr_ptr + 1'b1;
    assign rd_ptr_b = rd_ptr + 1'b1;

    // Readiness uses the pre-update count so freed slots are reused only next cycle.
    assign in_ready = (count <= CW'(DEPTH - 2));

    always_comb begin
        enq_num = 2'd0;
        if (!flush && in_ready) begin
            if (in_valid == 2'b11) begin
                enq_num = 2'd2;
            end else if (in_valid == 2'b01) begin
                enq_num = 2'd1;
            end
        end
    end

    assign out_valid_a = (count != '0);
    assign valid_b_raw = (count >= CW'(2));

`ifdef IQ_CTRL_SPLIT_EN
    logic [6:0] head_op;
    logic       head_ctrl;

    // Control-flow at the head issues alone; its neighbour waits for resolution.
    assign head_op     = instr_mem[rd_ptr][6:0];
    assign head_ctrl   = (head_op == 7'b1101111) || (head_op == 7'b1100111) ||
                         (head_op == 7'b1100011);
    assign out_valid_b = valid_b_raw && !head_ctrl;
`else
    assign out_valid_b = valid_b_raw;
`endif

    assign out_instr_a = out_valid_a ? instr_mem[rd_ptr]   : '0;
    assign out_pc_a    = out_valid_a ? pc_mem[rd_ptr]      : '0;
    assign out_instr_b = out_valid_b ? instr_mem[rd_ptr_b] : '0;
    assign out_pc_b    = out_valid_b ? pc_mem[rd_ptr_b]    : '0;

    always_comb begin
        deq_num = 2'd0;
        if (!flush && !stall_a && out_valid_a) begin
            if (stall_b || !out_valid_b) begin
                deq_num = 2'd1;
            end else begin
                deq_num = 2'd2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(enq_num);
            rd_ptr <= rd_ptr + PW'(deq_num);
            count  <= count + CW'(enq_num) - CW'(deq_num);
        end
    end

    // Entry storage needs no reset: reads are gated by count.
    always_ff @(posedge clk) begin
        if (enq_num != 2'd0) begin
            instr_mem[wr_ptr] <= in_instr_a;
            pc_mem[wr_ptr]    <= in_pc_a;
        end
        if (enq_num == 2'd2) begin
            instr_mem[wr_ptr_b] <= in_instr_b;
            pc_mem[wr_ptr_b]    <= in_pc_b;
        end
    end
endmodule

// File: tb/tb_dual_issue_instr_queue.sv
// tb/tb_dual_issue_instr_queue.sv - self-checking bench for dual_issue_instr_queue
module tb_dual_issue_instr_queue;
    localparam int DEPTH = 8;
    localparam int XLEN  = 32;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  in_valid = 2'b00;
    logic [31:0] in_instr_a = '0, in_instr_b = '0, in_pc_a = '0, in_pc_b = '0;
    logic        in_ready;
    logic        stall_a = 1'b0, stall_b = 1'b0, flush = 1'b0;
    logic        out_valid_a, out_valid_b;
    logic [31:0] out_instr_a, out_instr_b, out_pc_a, out_pc_b;
    logic [3:0]  count;

    ent_t         q[$];
    int           total = 0;
    int           bad = 0;
    logic [134:0] obs;
    logic [134:0] expv;

    localparam logic [134:0] RESET_VEC = 135'd1;

    dual_issue_instr_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_instr_a(in_instr_a), .in_instr_b(in_instr_b),
        .in_pc_a(in_pc_a), .in_pc_b(in_pc_b), .in_ready(in_ready),
        .stall_a(stall_a), .stall_b(stall_b), .flush(flush),
        .out_valid_a(out_valid_a), .out_valid_b(out_valid_b),
        .out_instr_a(out_instr_a), .out_instr_b(out_instr_b),
        .out_pc_a(out_pc_a), .out_pc_b(out_pc_b), .count(count)
    );

    always #5 clk = ~clk;

    assign obs = {out_valid_a, out_valid_b, out_instr_a, out_instr_b,
                  out_pc_a, out_pc_b, count, in_ready};

    function automatic bit is_ctrl(input logic [31:0] i);
        return (i[6:0] == 7'h6F) || (i[6:0] == 7'h67) || (i[6:0] == 7'h63);
    endfunction

    function automatic bit split_en();
`ifdef IQ_CTRL_SPLIT_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit model_vb();
        return (q.size() >= 2) && !(split_en() && is_ctrl(q[0].instr));
    endfunction

    task automatic model_expect();
        logic        va, vb;
        logic [31:0] ia, ib, pa, pb;
        va = (q.size() >= 1);
        vb = model_vb();
        ia = va ? q[0].instr : 32'h0;
        pa = va ? q[0].pc    : 32'h0;
        ib = vb ? q[1].instr : 32'h0;
        pb = vb ? q[1].pc    : 32'h0;
        expv = {va, vb, ia, ib, pa, pb, 4'(q.size()), (q.size() <= DEPTH - 2)};
    endtask

    // Drive one cycle from a negedge, advance the model across the posedge, return at the next negedge.
    task automatic cycle(input logic [1:0] v, input logic [31:0] ia, pa, ib, pb,
                         input logic sa, sb, fl);
        int   sz, d;
        bit   rdy, vb;
        ent_t ea, eb;
        in_valid = v; in_instr_a = ia; in_pc_a = pa; in_instr_b = ib; in_pc_b = pb;
        stall_a = sa; stall_b = sb; flush = fl;
        sz  = q.size();
        rdy = (sz <= DEPTH - 2);
        vb  = model_vb();
        ea  = '{instr: ia, pc: pa};
        eb  = '{instr: ib, pc: pb};
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            d = sa ? 0 : ((sb || !vb) ? 1 : 2);
            if (d > sz) d = sz;
            repeat (d) void'(q.pop_front());
            if (rdy && v == 2'b11) begin
                q.push_back(ea);
                q.push_back(eb);
            end else if (rdy && v == 2'b01) begin
                q.push_back(ea);
            end
        end
        @(negedge clk);
        in_valid = 2'b00; stall_a = 1'b0; stall_b = 1'b0; flush = 1'b0;
    endtask

    task automatic idle();
        cycle(2'b00, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if (obs !== RESET_VEC) begin
            bad++;
            $display("FAIL reset_state got=%h want=%h", obs, RESET_VEC);
        end
        rst_n = 1'b1;
        q.delete();
    endtask

    task automatic test_basic_pair();
        cycle(2'b11, 32'h13, 32'h0, 32'h33, 32'h4, 1'b0, 1'b0, 1'b0);
        total++;
        if (!out_valid_a || !out_valid_b || out_pc_a !== 32'h0 || out_pc_b !== 32'h4) begin
            bad++;
            $display("FAIL basic_pair va=%b vb=%b pa=%h pb=%h want 1 1 0 4",
                     out_valid_a, out_valid_b, out_pc_a, out_pc_b);
        end
        idle();
        total++;
        if (count !== 4'd0 || out_valid_a || out_valid_b) begin
            bad++;
            $display("FAIL basic_drain count=%0d va=%b vb=%b want 0 0 0",
                     count, out_valid_a, out_valid_b);
        end
    endtask

    task automatic test_fill();
        for (int k = 0; k < 4; k++)
            cycle(2'b11, 32'h13, 32'h100 + 8 * k, 32'h13, 32'h104 + 8 * k, 1'b1, 1'b0, 1'b0);
        total++;
        if (count !== 4'd8 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL fill_full count=%0d ready=%b want 8 0", count, in_ready);
        end
        cycle(2'b11, 32'h13, 32'h900, 32'h13, 32'h904, 1'b1, 1'b0, 1'b0);
        total++;
        if (count !== 4'd8 || out_pc_a !== 32'h100) begin
            bad++;
            $display("FAIL fill_reject count=%0d pa=%h want 8 100", count, out_pc_a);
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (out_pc_a !== 32'h100 + 8 * k || out_pc_b !== 32'h104 + 8 * k || !out_valid_b) begin
                bad++;
                $display("FAIL fill_drain k=%0d pa=%h pb=%h vb=%b want %h %h 1", k,
                         out_pc_a, out_pc_b, out_valid_b, 32'h100 + 8 * k, 32'h104 + 8 * k);
            end
            idle();
        end
        total++;
        if (count !== 4'd0) begin
            bad++;
            $display("FAIL fill_empty count=%0d want 0", count);
        end
    endtask

    task automatic test_stall_b();
        cycle(2'b11, 32'h13, 32'h10, 32'h13, 32'h14, 1'b1, 1'b0, 1'b0);
        cycle(2'b01, 32'h13, 32'h18, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        cycle(2'b00, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        total++;
        if (out_pc_a !== 32'h14 || out_pc_b !== 32'h18 || count !== 4'd2) begin
            bad++;
            $display("FAIL stall_b_split pa=%h pb=%h count=%0d want 14 18 2",
                     out_pc_a, out_pc_b, count);
        end
        idle();
        model_expect();
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL stall_b_drain got=%h want=%h", obs, expv);
        end
    endtask

    task automatic test_wrap();
        cycle(2'b00, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++)
            cycle(2'b01, 32'h13, 32'h200 + 4 * i, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle(2'b11, 32'h0000_1013, 32'h300, 32'h0000_2013, 32'h304, 1'b0, 1'b0, 1'b0);
        total++;
        if (out_pc_a !== 32'h300 || out_pc_b !== 32'h304 || out_instr_a !== 32'h1013 ||
            out_instr_b !== 32'h2013) begin
            bad++;
            $display("FAIL wrap_pair pa=%h pb=%h ia=%h ib=%h want 300 304 1013 2013",
                     out_pc_a, out_pc_b, out_instr_a, out_instr_b);
        end
        idle();
        model_expect();
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL wrap_drain got=%h want=%h", obs, expv);
        end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++)
            cycle(2'b11, 32'h13, 32'h500 + 8 * k, 32'h13, 32'h504 + 8 * k, 1'b1, 1'b0, 1'b0);
        total++;
        if (count !== 4'd6) begin
            bad++;
            $display("FAIL flush_setup count=%0d want 6", count);
        end
        cycle(2'b11, 32'h13, 32'h600, 32'h13, 32'h604, 1'b0, 1'b0, 1'b1);
        total++;
        if (count !== 4'd0 || out_valid_a || out_valid_b || in_ready !== 1'b1 ||
            out_pc_a !== 32'h0) begin
            bad++;
            $display("FAIL flush_empty count=%0d va=%b vb=%b ready=%b pa=%h want 0 0 0 1 0",
                     count, out_valid_a, out_valid_b, in_ready, out_pc_a);
        end
    endtask

    task automatic test_ctrl_split();
        cycle(2'b11, 32'h0000_006F, 32'h400, 32'h0000_0033, 32'h404, 1'b0, 1'b0, 1'b0);
        total++;
        if (out_valid_a !== 1'b1 || out_valid_b !== !split_en()) begin
            bad++;
            $display("FAIL ctrl_pair va=%b vb=%b want 1 %b", out_valid_a, out_valid_b, !split_en());
        end
        idle();
        model_expect();
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL ctrl_after got=%h want=%h", obs, expv);
        end
        idle();
    endtask

    task automatic test_async_reset();
        cycle(2'b11, 32'h13, 32'h700, 32'h13, 32'h704, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (obs !== RESET_VEC) begin
            bad++;
            $display("FAIL async_reset got=%h want=%h", obs, RESET_VEC);
        end
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [1:0]  v;
        logic [31:0] ia, ib;
        for (int n = 0; n < 400; n++) begin
            model_expect();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL random n=%0d got=%h want=%h", n, obs, expv);
            end
            v  = 2'($urandom_range(0, 3));
            ia = $urandom;
            ib = $urandom;
            if ($urandom_range(0, 3) == 0) ia[6:0] = 7'h63;
            cycle(v, ia, $urandom, ib, $urandom, ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 19) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_basic_pair();
        test_fill();
        test_stall_b();
        test_wrap();
        test_flush();
        test_ctrl_split();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
